// File: rtl/shift_req_buffer.sv
// rtl/shift_req_buffer.sv - request FIFO and registered result stage around a combinational right shifter
// Optional same-cycle bypass of an empty FIFO: define SHIFT_REQ_BYPASS_EN.
module shift_req_buffer #(
   parameter int DEPTH = 4,
   parameter int LVL_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic [2:0]       in_shift,
   output logic [7:0]       sh_datain,
   output logic [2:0]       sh_shift,
   input  logic [7:0]       sh_dataout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic [2:0]       out_shift,
   output logic [LVL_W-1:0] level
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [7:0]       mem_data  [DEPTH];
   logic [2:0]       mem_shift [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   logic empty;
   logic full;
   logic out_free;
   logic accept;
   logic bypass;
   logic push;
   logic pop;

   assign empty    = (level == '0);
   assign full     = (level == LVL_W'(DEPTH));
   assign in_ready = rst_n && !full;
   assign accept   = in_valid && in_ready;
   assign out_free = !out_valid || out_ready;
   assign pop      = !empty && out_free;

`ifdef SHIFT_REQ_BYPASS_EN
   // An empty FIFO with a free result register lets the request go straight to the shifter.
   assign bypass = empty && accept && out_free;
`else
   assign bypass = 1'b0;
`endif

   assign push = accept && !bypass;

   always_comb begin
      sh_datain = 8'h00;
      sh_shift  = 3'd0;
      if (!empty) begin
         sh_datain = mem_data[rd_ptr];
         sh_shift  = mem_shift[rd_ptr];
      end else if (bypass) begin
         sh_datain = in_data;
         sh_shift  = in_shift;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr]  <= in_data;
         mem_shift[wr_ptr] <= in_shift;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= 8'h00;
         out_shift <= 3'd0;
      end else if (pop || bypass) begin
         out_valid <= 1'b1;
         out_data  <= sh_dataout;
         out_shift <= sh_shift;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shift_req_buffer.sv
// tb/tb_shift_req_buffer.sv - scoreboard bench for shift_req_buffer with a behavioural shifter
module tb_shift_req_buffer;

   localparam int DEPTH = 4;
   localparam int LVL_W = 3;
`ifdef SHIFT_REQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_data;
   logic [2:0]       in_shift;
   logic [7:0]       sh_datain;
   logic [2:0]       sh_shift;
   logic [7:0]       sh_dataout;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_data;
   logic [2:0]       out_shift;
   logic [LVL_W-1:0] level;

   int checks = 0;
   int errors = 0;
   int received = 0;
   logic [10:0] exp_q[$];

   always #5 clk = ~clk;

   // The shifter itself: logical right shift, zero fill.
   assign sh_dataout = sh_datain >> sh_shift;

   shift_req_buffer #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_shift(in_shift),
      .sh_datain(sh_datain), .sh_shift(sh_shift), .sh_dataout(sh_dataout),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_shift(out_shift),
      .level(level)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Every accepted request predicts one result; reset wipes all predictions.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else if (in_valid && in_ready) begin
         exp_q.push_back({in_data >> in_shift, in_shift});
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         received++;
         if (exp_q.size() == 0) begin
            chk("unexpected_result", {out_data, out_shift}, 11'h7ff);
         end else begin
            chk("scoreboard_result", {out_data, out_shift}, exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] bb_data [4];
      logic [2:0] bb_shift [4];
      logic [7:0] first_res;
      int acc;
      int sent;
      int cyc;
      logic take;

      bb_data  = '{8'hFF, 8'h80, 8'h81, 8'hF0};
      bb_shift = '{3'd7, 3'd4, 3'd0, 3'd1};

      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_shift = 3'd0; out_ready = 1'b0;
      #1;
      chk("in_ready_in_reset", in_ready, 0);
      step(); step();
      chk("reset_out_valid", out_valid, 0);
      chk("reset_level", level, 0);
      chk("reset_out_data", out_data, 8'h00);
      chk("reset_out_shift", out_shift, 0);
      chk("reset_sh_datain", sh_datain, 8'h00);
      rst_n = 1'b1;
      step();

      // Single request latency
      in_valid = 1'b1; in_data = 8'hB4; in_shift = 3'd2; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("lat_edge_n_valid", out_valid, BYP);
      chk("lat_edge_n_level", level, BYP ? 0 : 1);
      if (BYP) chk("lat_data_bypass", out_data, 8'h2D);
      step();
      chk("lat_edge_n1_valid", out_valid, !BYP);
      chk("lat_edge_n1_level", level, 0);
      if (!BYP) begin
         chk("lat_data", out_data, 8'h2D);
         chk("lat_shift", out_shift, 2);
      end
      step(); step();

      // Back-to-back with continuous out_ready
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = bb_data[i]; in_shift = bb_shift[i];
         chk("b2b_in_ready", in_ready, 1);
         step();
         if (i > 0) chk("b2b_out_valid", out_valid, 1);
      end
      in_valid = 1'b0;
      step(); step(); step();
      chk("b2b_drained", exp_q.size(), 0);

      // Fill with out_ready low
      out_ready = 1'b0; acc = 0; first_res = 8'h00;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_data = 8'($urandom); in_shift = 3'($urandom);
         if (in_ready) begin
            if (acc == 0) first_res = in_data >> in_shift;
            acc++;
         end
         step();
      end
      chk("full_accepted", acc, DEPTH + 1);
      chk("full_in_ready", in_ready, 0);
      chk("full_level", level, DEPTH);
      chk("full_out_data_stable", out_data, first_res);
      chk("full_out_valid", out_valid, 1);

      // One pop from full, then simultaneous push and pop
      out_ready = 1'b1;
      step();
      chk("pop_level", level, DEPTH - 1);
      chk("pop_in_ready", in_ready, 1);
      in_data = 8'($urandom); in_shift = 3'($urandom);
      step();
      chk("pushpop_level", level, DEPTH - 1);
      in_valid = 1'b0; out_ready = 1'b0;

      // Reset mid-operation
      chk("pre_reset_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_in_ready", in_ready, 0);
      step();
      rst_n = 1'b1;
      chk("mid_reset_out_valid", out_valid, 0);
      chk("mid_reset_level", level, 0);
      chk("mid_reset_out_data", out_data, 8'h00);
      step();

      // Randomized traffic
      received = 0; sent = 0; cyc = 0;
      while (sent < 1000 && cyc < 20000) begin
         if (!in_valid) begin
            in_valid = 1'($urandom);
            in_data = 8'($urandom); in_shift = 3'($urandom);
         end
         out_ready = 1'($urandom);
         take = in_valid && in_ready;
         step();
         cyc++;
         if (take) begin
            sent++;
            in_valid = 1'b0;
         end
      end
      chk("random_sent_in_budget", sent, 1000);
      in_valid = 1'b0; out_ready = 1'b1;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 100) begin
         step();
         cyc++;
      end
      step();
      chk("random_drained", exp_q.size(), 0);
      chk("random_received", received, sent);
      chk("random_final_level", level, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
